// File: rtl/counter_run_if.sv
// Enabler/counter-side bundle of the run controller.
// master: the controller (drives rate_sel/restart/enable/clear, observes tick/count).
// slave:  the datapath (rate enabler + count register).
interface counter_run_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tick;
    logic [WIDTH-1:0] count;
    logic [1:0]       rate_sel;
    logic             div_restart;
    logic             count_en;
    logic             count_clr;

    modport master (
        input  tick,
        input  count,
        output rate_sel,
        output div_restart,
        output count_en,
        output count_clr
    );

    modport slave (
        output tick,
        output count,
        input  rate_sel,
        input  div_restart,
        input  count_en,
        input  count_clr
    );
endinterface

// File: rtl/counter_run_controller.sv
// Run/pause/stop sequencer for the rate-enabled up-counter.
// Optional feature macro: COUNTER_RUN_AUTO_RELOAD_EN (terminal count clears and
// keeps running, done becomes a one-cycle pulse; DONE state never entered).
module counter_run_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             clear_n,
    input  logic             start_n,
    input  logic             stop_n,
    input  logic [1:0]       rate_req,
    input  logic [WIDTH-1:0] target,
    counter_run_if.master    dp,
    output logic [1:0]       state,
    output logic             done
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // [0] first sync stage, [1] second sync stage, [2] edge-detect history
    localparam int unsigned SYNC_W = 3;

    logic [SYNC_W-1:0] start_sync_q, start_sync_d;
    logic [SYNC_W-1:0] stop_sync_q,  stop_sync_d;
    state_e            state_q,       state_d;
    logic [1:0]        rate_sel_q,    rate_sel_d;
    logic              div_restart_q, div_restart_d;
    logic              count_clr_q,   count_clr_d;
    logic              done_q,        done_d;

    logic start_p_c;
    logic stop_p_c;
    logic start_go_c;
    logic count_en_c;
    logic terminal_c;
    logic [WIDTH-1:0] last_count_c;

    // Button synchronisers and falling-edge pulses
    always_comb begin
        start_sync_d = {start_sync_q[SYNC_W-2:0], start_n};
        stop_sync_d  = {stop_sync_q[SYNC_W-2:0],  stop_n};
        start_p_c    = start_sync_q[2] & ~start_sync_q[1];
        stop_p_c     = stop_sync_q[2]  & ~stop_sync_q[1];
        // stop has priority over a coincident start
        start_go_c   = start_p_c & ~stop_p_c;
    end

    // Increment strobe and terminal detect; target 0 wraps at all-ones
    always_comb begin
        count_en_c   = dp.tick && (state_q == ST_RUN) && !stop_p_c;
        last_count_c = target - WIDTH'(1);
        terminal_c   = count_en_c && (dp.count == last_count_c);
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        rate_sel_d    = rate_sel_q;
        div_restart_d = 1'b0;
        count_clr_d   = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_go_c) begin
                    state_d       = ST_RUN;
                    rate_sel_d    = rate_req;
                    div_restart_d = 1'b1;
                    count_clr_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_p_c) begin
                    state_d = ST_PAUSE;
                end else if (terminal_c) begin
`ifdef COUNTER_RUN_AUTO_RELOAD_EN
                    count_clr_d = 1'b1;
                    done_d      = 1'b1;
`else
                    state_d     = ST_DONE;
`endif
                end
            end
            ST_PAUSE: begin
                if (stop_p_c) begin
                    state_d     = ST_IDLE;
                    count_clr_d = 1'b1;
                end else if (start_go_c) begin
                    // resume keeps the latched rate; restart gives a full first period
                    state_d       = ST_RUN;
                    div_restart_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (stop_p_c) begin
                    state_d     = ST_IDLE;
                    count_clr_d = 1'b1;
                end else if (start_go_c) begin
                    state_d       = ST_RUN;
                    rate_sel_d    = rate_req;
                    div_restart_d = 1'b1;
                    count_clr_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifndef COUNTER_RUN_AUTO_RELOAD_EN
        done_d = (state_d == ST_DONE);
`endif
    end

    // State and output registers; synchronisers preset to released
    always_ff @(posedge CLOCK_50 or negedge clear_n) begin
        if (!clear_n) begin
            start_sync_q  <= '1;
            stop_sync_q   <= '1;
            state_q       <= ST_IDLE;
            rate_sel_q    <= 2'b00;
            div_restart_q <= 1'b0;
            count_clr_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            start_sync_q  <= start_sync_d;
            stop_sync_q   <= stop_sync_d;
            state_q       <= state_d;
            rate_sel_q    <= rate_sel_d;
            div_restart_q <= div_restart_d;
            count_clr_q   <= count_clr_d;
            done_q        <= done_d;
        end
    end

    assign state          = state_q;
    assign done           = done_q;
    assign dp.rate_sel    = rate_sel_q;
    assign dp.div_restart = div_restart_q;
    assign dp.count_clr   = count_clr_q;
    assign dp.count_en    = count_en_c;

endmodule

// File: tb/tb_counter_run_controller.sv
// Bench for counter_run_controller: directed scenarios then random buttons/ticks,
// checked every cycle against a reference model that also plays the counter.
module tb_counter_run_controller;
    localparam int unsigned WIDTH = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic             clk = 1'b0;
    logic             clear_n;
    logic             start_n;
    logic             stop_n;
    logic [1:0]       rate_req;
    logic [WIDTH-1:0] target;
    logic [1:0]       state;
    logic             done;

    counter_run_if #(.WIDTH(WIDTH)) dp_if ();

    counter_run_controller #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (clk),
        .clear_n  (clear_n),
        .start_n  (start_n),
        .stop_n   (stop_n),
        .rate_req (rate_req),
        .target   (target),
        .dp       (dp_if),
        .state    (state),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs for the current cycle, the counter
    // value, and the last three clock-edge samples of each button ([0] newest).
    logic [1:0]       m_state;
    logic [1:0]       m_rate;
    logic             m_done;
    logic             m_restart;
    logic             m_clr;
    logic [WIDTH-1:0] m_count;
    logic [2:0]       h_start;
    logic [2:0]       h_stop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = S_IDLE;
        m_rate    = 2'b00;
        m_done    = 1'b0;
        m_restart = 1'b0;
        m_clr     = 1'b0;
        m_count   = '0;
        h_start   = 3'b111;
        h_stop    = 3'b111;
    endtask

    // One clock cycle: inputs are already driven (called just after a negedge).
    task automatic cycle();
        logic sp, tp, go, en, term;
        logic [1:0] n_state, n_rate;
        logic n_done, n_rst, n_clr;
        logic [WIDTH-1:0] last;
        dp_if.count = m_count;
        #1;
        // a press is seen once a released sample is followed by a pressed one
        sp   = h_start[2] & ~h_start[1];
        tp   = h_stop[2]  & ~h_stop[1];
        go   = sp & ~tp;
        en   = dp_if.tick && (m_state == S_RUN) && !tp;
        check("count_en", 32'(dp_if.count_en), 32'(en));
        last = target - WIDTH'(1);
        term = en && (m_count == last);

        n_state = m_state;
        n_rate  = m_rate;
        n_rst   = 1'b0;
        n_clr   = 1'b0;
        n_done  = 1'b0;
        if (m_state == S_RUN) begin
            if (tp) n_state = S_PAUSE;
            else if (term) begin
`ifdef COUNTER_RUN_AUTO_RELOAD_EN
                n_clr  = 1'b1;
                n_done = 1'b1;
`else
                n_state = S_DONE;
`endif
            end
        end else if (tp) begin
            if (m_state != S_IDLE) begin
                n_state = S_IDLE;
                n_clr   = 1'b1;
            end
        end else if (go) begin
            n_state = S_RUN;
            n_rst   = 1'b1;
            if (m_state != S_PAUSE) begin
                n_rate = rate_req;
                n_clr  = 1'b1;
            end
        end
`ifndef COUNTER_RUN_AUTO_RELOAD_EN
        n_done = (n_state == S_DONE);
`endif

        @(posedge clk);
        if (m_clr) m_count = '0;
        else if (en) m_count = m_count + WIDTH'(1);
        h_start   = {h_start[1:0], start_n};
        h_stop    = {h_stop[1:0],  stop_n};
        m_state   = n_state;
        m_rate    = n_rate;
        m_done    = n_done;
        m_restart = n_rst;
        m_clr     = n_clr;

        @(negedge clk);
        dp_if.count = m_count;
        check("state",       32'(state),             32'(m_state));
        check("done",        32'(done),              32'(m_done));
        check("rate_sel",    32'(dp_if.rate_sel),    32'(m_rate));
        check("div_restart", 32'(dp_if.div_restart), 32'(m_restart));
        check("count_clr",   32'(dp_if.count_clr),   32'(m_clr));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold a button low for hold cycles, then release and settle.
    task automatic press(input bit do_start, input bit do_stop, input int hold);
        if (do_start) start_n = 1'b0;
        if (do_stop)  stop_n  = 1'b0;
        cycles(hold);
        start_n = 1'b1;
        stop_n  = 1'b1;
        cycles(4);
    endtask

    int start_hold;
    int stop_hold;

    initial begin
        clear_n     = 1'b0;
        start_n     = 1'b1;
        stop_n      = 1'b1;
        rate_req    = 2'b00;
        target      = '0;
        dp_if.tick  = 1'b0;
        dp_if.count = '0;
        model_reset();

        // reset: quiet outputs, no count_en while tick toggles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dp_if.tick = ~dp_if.tick;
            #1;
            check("rst_state",    32'(state),              32'(S_IDLE));
            check("rst_rate",     32'(dp_if.rate_sel),     32'd0);
            check("rst_done",     32'(done),               32'd0);
            check("rst_restart",  32'(dp_if.div_restart),  32'd0);
            check("rst_clr",      32'(dp_if.count_clr),    32'd0);
            check("rst_count_en", 32'(dp_if.count_en),     32'd0);
        end
        @(negedge clk);
        clear_n    = 1'b1;
        dp_if.tick = 1'b0;
        cycles(3);

        // start with rate 2: RUN three edges after the press
        rate_req = 2'b10;
        start_n  = 1'b0;
        cycles(3);
        check("start_latency_state", 32'(state), 32'(S_RUN));
        check("start_rate_sel", 32'(dp_if.rate_sel), 32'd2);
        cycles(2);
        start_n  = 1'b1;
        rate_req = 2'b01;
        cycles(4);
        check("rate_ignored", 32'(dp_if.rate_sel), 32'd2);

        // target 5, a tick every 4 cycles, run past the terminal count
        target = WIDTH'(5);
        for (int i = 0; i < 40; i++) begin
            dp_if.tick = (i % 4 == 3);
            cycle();
        end
        dp_if.tick = 1'b0;
`ifdef COUNTER_RUN_AUTO_RELOAD_EN
        check("t5_state", 32'(state), 32'(S_RUN));
`else
        check("t5_state", 32'(state), 32'(S_DONE));
        check("t5_done",  32'(done),  32'd1);
`endif

        // restart, then stop press landing on a tick
        press(1'b1, 1'b0, 5);
        target     = WIDTH'(200);
        dp_if.tick = 1'b1;
        stop_n     = 1'b0;
        cycles(4);
        dp_if.tick = 1'b0;
        stop_n     = 1'b1;
        cycles(3);
        check("stop_state", 32'(state), 32'(S_PAUSE));
        press(1'b1, 1'b0, 3);
        check("resume_state", 32'(state), 32'(S_RUN));

        // coincident start and stop in RUN: stop wins
        press(1'b1, 1'b1, 5);
        check("both_state", 32'(state), 32'(S_PAUSE));
        press(1'b0, 1'b1, 2);
        check("pause_stop_state", 32'(state), 32'(S_IDLE));
        press(1'b1, 1'b0, 2);

        // full-range target: terminal at all-ones
        target     = '0;
        m_count    = '1;
        dp_if.tick = 1'b1;
        cycle();
        dp_if.tick = 1'b0;
`ifdef COUNTER_RUN_AUTO_RELOAD_EN
        check("wrap_state", 32'(state), 32'(S_RUN));
        check("wrap_done_pulse", 32'(done), 32'd1);
        check("wrap_clr_pulse", 32'(dp_if.count_clr), 32'd1);
`else
        check("wrap_state", 32'(state), 32'(S_DONE));
`endif
        cycles(2);

        // back to RUN, then asynchronous reset mid-run
        press(1'b1, 1'b0, 2);
        clear_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'(S_IDLE));
        check("async_rst_rate",  32'(dp_if.rate_sel), 32'd0);
        check("async_rst_clr",   32'(dp_if.count_clr), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        cycles(2);

        // random buttons, ticks, targets and rate requests
        start_hold = 0;
        stop_hold  = 0;
        for (int i = 0; i < 3000; i++) begin
            dp_if.tick = ($urandom % 3 == 0);
            rate_req   = 2'($urandom % 4);
            if ($urandom % 40 == 0) target = WIDTH'($urandom_range(0, 12));
            if (start_hold == 0 && $urandom % 12 == 0) start_hold = int'($urandom_range(1, 6));
            if (stop_hold  == 0 && $urandom % 25 == 0) stop_hold  = int'($urandom_range(1, 6));
            start_n = (start_hold == 0);
            stop_n  = (stop_hold  == 0);
            if (start_hold > 0) start_hold--;
            if (stop_hold  > 0) stop_hold--;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
